// File: rtl/fwd_scoreboard_pkg.sv
// Shared types for the decode/execute operand forwarding and hazard logic.
package fwd_scoreboard_pkg;

  localparam int unsigned CREG_NUM = 32;
  localparam int unsigned CREG_AW  = $clog2(CREG_NUM);

  typedef logic [CREG_AW-1:0] creg_addr_t;

  typedef enum logic [2:0] {
    FWD_RF  = 3'd0,
    FWD_EXE = 3'd1,
    FWD_MEM = 3'd2,
    FWD_MC  = 3'd3,
    FWD_PC  = 3'd4
  } fwd_src_e;

endpackage

// File: rtl/fwd_scoreboard_port_mux.sv
// One source-operand port: picks pc/exe/mem/mc/regfile data and flags a
// load-use or pending-multicycle stall for that port. Purely combinational.
module fwd_port_mux
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]    rs_i,
  input  logic [WIDTH-1:0] rf_data_i,
  input  logic             use_pc_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             exe_regwrite_i,
  input  logic [AW-1:0]    exe_dst_i,
  input  logic             exe_is_load_i,
  input  logic [WIDTH-1:0] exe_data_i,
  input  logic             mem_regwrite_i,
  input  logic [AW-1:0]    mem_dst_i,
  input  logic [WIDTH-1:0] mem_data_i,
  input  logic             mc_done_i,
  input  logic [AW-1:0]    mc_dst_i,
  input  logic [WIDTH-1:0] mc_data_i,
  input  logic             pend_hit_i,
  output logic [WIDTH-1:0] data_o,
  output logic             stall_o
);

  logic     rs_nz, exe_hit, mem_hit, mc_hit;
  fwd_src_e src;

  assign rs_nz   = (rs_i != '0);
  assign exe_hit = rs_nz && exe_regwrite_i && (exe_dst_i == rs_i);
  assign mem_hit = rs_nz && mem_regwrite_i && (mem_dst_i == rs_i);
  assign mc_hit  = rs_nz && mc_done_i && (mc_dst_i == rs_i);

  always_comb begin
    src = FWD_RF;
    if (use_pc_i)     src = FWD_PC;
    else if (exe_hit) src = FWD_EXE;
    else if (mem_hit) src = FWD_MEM;
    else if (mc_hit)  src = FWD_MC;
  end

  always_comb begin
    data_o = rf_data_i;
    case (src)
      FWD_PC:  data_o = pc_i;
      FWD_EXE: data_o = exe_data_i;
      FWD_MEM: data_o = mem_data_i;
      FWD_MC:  data_o = mc_data_i;
      default: data_o = rs_nz ? rf_data_i : '0;
    endcase
  end

  // A pc-sourced port reads no register, so it can never hazard.
  assign stall_o = !use_pc_i && rs_nz &&
                   ((exe_hit && exe_is_load_i) || (pend_hit_i && !mc_hit));

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding for NREAD ports plus a pending-write scoreboard for
// multicycle producers; raises stall on load-use, pending-read and WAW hazards.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NREAD = 2,
  parameter int unsigned NREG  = 32,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [NREAD-1:0][AW-1:0]    rs_i,
  input  logic [NREAD-1:0][WIDTH-1:0] rf_data_i,
  input  logic                        pc_sel_i,
  input  logic [WIDTH-1:0]            pc_i,
  input  logic                        issue_valid_i,
  input  logic                        issue_regwrite_i,
  input  logic [AW-1:0]               issue_dst_i,
  input  logic                        issue_mc_i,
  input  logic                        exe_regwrite_i,
  input  logic [AW-1:0]               exe_dst_i,
  input  logic                        exe_is_load_i,
  input  logic [WIDTH-1:0]            exe_data_i,
  input  logic                        mem_regwrite_i,
  input  logic [AW-1:0]               mem_dst_i,
  input  logic [WIDTH-1:0]            mem_data_i,
  input  logic                        mc_done_i,
  input  logic [AW-1:0]               mc_dst_i,
  input  logic [WIDTH-1:0]            mc_data_i,
  output logic [NREAD-1:0][WIDTH-1:0] fwd_data_o,
  output logic                        stall_o,
  output logic [31:0]                 stall_cnt_o
);

  logic [NREG-1:0]  pending_q, pending_d, pend_eff;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [NREAD-1:0] port_stall;
  logic             waw, accept;

  // While reset is held the scoreboard is treated as empty.
  assign pend_eff = reset_ni ? pending_q : '0;

  for (genvar g = 0; g < NREAD; g++) begin : g_port
    fwd_port_mux #(.NREG(NREG), .WIDTH(WIDTH)) u_mux (
      .rs_i           (rs_i[g]),
      .rf_data_i      (rf_data_i[g]),
      .use_pc_i       (pc_sel_i && (g == 0)),
      .pc_i           (pc_i),
      .exe_regwrite_i (exe_regwrite_i),
      .exe_dst_i      (exe_dst_i),
      .exe_is_load_i  (exe_is_load_i),
      .exe_data_i     (exe_data_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_dst_i      (mem_dst_i),
      .mem_data_i     (mem_data_i),
      .mc_done_i      (mc_done_i),
      .mc_dst_i       (mc_dst_i),
      .mc_data_i      (mc_data_i),
      .pend_hit_i     (pend_eff[rs_i[g]]),
      .data_o         (fwd_data_o[g]),
      .stall_o        (port_stall[g])
    );
  end

  assign waw = issue_regwrite_i && (issue_dst_i != '0) && pend_eff[issue_dst_i] &&
               !(mc_done_i && (mc_dst_i == issue_dst_i));

  assign stall_o = issue_valid_i && ((|port_stall) || waw);
  assign accept  = issue_valid_i && !stall_o && issue_mc_i && issue_regwrite_i &&
                   (issue_dst_i != '0);

  always_comb begin
    pending_d = pending_q;
    if (mc_done_i) pending_d[mc_dst_i] = 1'b0;
    // Set after clear so a new producer wins over a same-cycle completion.
    if (accept) pending_d[issue_dst_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed-vector bench for fwd_scoreboard with hand-computed expectations.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int unsigned NREAD = 2;
  localparam int unsigned NREG  = 32;
  localparam int unsigned WIDTH = 64;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic [NREAD-1:0][4:0]       rs;
  logic [NREAD-1:0][WIDTH-1:0] rf_data;
  logic                        pc_sel;
  logic [WIDTH-1:0]            pc;
  logic                        issue_valid, issue_regwrite, issue_mc;
  creg_addr_t                  issue_dst;
  logic                        exe_regwrite, exe_is_load;
  creg_addr_t                  exe_dst;
  logic [WIDTH-1:0]            exe_data;
  logic                        mem_regwrite;
  creg_addr_t                  mem_dst;
  logic [WIDTH-1:0]            mem_data;
  logic                        mc_done;
  creg_addr_t                  mc_dst;
  logic [WIDTH-1:0]            mc_data;
  logic [NREAD-1:0][WIDTH-1:0] fwd_data;
  logic                        stall;
  logic [31:0]                 stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NREAD(NREAD), .NREG(NREG), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .reset_ni(reset_n), .rs_i(rs), .rf_data_i(rf_data),
    .pc_sel_i(pc_sel), .pc_i(pc), .issue_valid_i(issue_valid),
    .issue_regwrite_i(issue_regwrite), .issue_dst_i(issue_dst), .issue_mc_i(issue_mc),
    .exe_regwrite_i(exe_regwrite), .exe_dst_i(exe_dst), .exe_is_load_i(exe_is_load),
    .exe_data_i(exe_data), .mem_regwrite_i(mem_regwrite), .mem_dst_i(mem_dst),
    .mem_data_i(mem_data), .mc_done_i(mc_done), .mc_dst_i(mc_dst), .mc_data_i(mc_data),
    .fwd_data_o(fwd_data), .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs = '0; rf_data = '0; pc_sel = 0; pc = '0;
    issue_valid = 0; issue_regwrite = 0; issue_dst = '0; issue_mc = 0;
    exe_regwrite = 0; exe_dst = '0; exe_is_load = 0; exe_data = '0;
    mem_regwrite = 0; mem_dst = '0; mem_data = '0;
    mc_done = 0; mc_dst = '0; mc_data = '0;
  endtask

  // Advance one clock edge and leave inputs settled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_mc_op(input creg_addr_t dst);
    idle();
    issue_valid = 1; issue_regwrite = 1; issue_mc = 1; issue_dst = dst;
    #1 chk("mc_issue_accept", {63'd0, stall}, 64'd0);
    tick();
  endtask

  initial begin
    idle();
    reset_n = 0;
    tick();
    #1 chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_cnt", {32'd0, stall_cnt}, 64'd0);
    reset_n = 1;
    tick();

    // exe beats mem on the same destination
    idle();
    issue_valid = 1;
    exe_regwrite = 1; exe_dst = 5; exe_data = 64'h11;
    mem_regwrite = 1; mem_dst = 5; mem_data = 64'h22;
    rs[0] = 5; rf_data[0] = 64'hDEAD;
    rs[1] = 9; rf_data[1] = 64'h1234;
    #1 chk("exe_prio", fwd_data[0], 64'h11);
    chk("rf_pass", fwd_data[1], 64'h1234);
    chk("exe_nostall", {63'd0, stall}, 64'd0);
    tick();

    // load-use: one stalled cycle, then forwarded from memory
    idle();
    issue_valid = 1; rs[1] = 6;
    exe_regwrite = 1; exe_dst = 6; exe_is_load = 1;
    #1 chk("loaduse_stall", {63'd0, stall}, 64'd1);
    tick();
    idle();
    issue_valid = 1; rs[1] = 6;
    mem_regwrite = 1; mem_dst = 6; mem_data = 64'hABCD;
    #1 chk("load_mem_fwd", fwd_data[1], 64'hABCD);
    chk("load_mem_nostall", {63'd0, stall}, 64'd0);
    chk("load_cnt", {32'd0, stall_cnt}, 64'd1);
    tick();

    // divide to x7, reader waits 10 cycles, completion forwarded same cycle
    issue_mc_op(5'd7);
    idle();
    issue_valid = 1; rs[0] = 7; rf_data[0] = 64'h55;
    for (int i = 0; i < 10; i++) begin
      #1 chk("mc_pending_stall", {63'd0, stall}, 64'd1);
      tick();
    end
    mc_done = 1; mc_dst = 7; mc_data = 64'h99;
    #1 chk("mc_same_cycle_fwd", fwd_data[0], 64'h99);
    chk("mc_done_nostall", {63'd0, stall}, 64'd0);
    tick();
    mc_done = 0;
    #1 chk("mc_cleared_nostall", {63'd0, stall}, 64'd0);
    chk("mc_cleared_rf", fwd_data[0], 64'h55);
    chk("mc_cnt", {32'd0, stall_cnt}, 64'd11);
    tick();

    // WAW, then set-wins on simultaneous completion and re-issue
    issue_mc_op(5'd7);
    idle();
    issue_valid = 1; issue_regwrite = 1; issue_dst = 7;
    #1 chk("waw_stall", {63'd0, stall}, 64'd1);
    tick();
    idle();
    issue_valid = 1; issue_regwrite = 1; issue_mc = 1; issue_dst = 7;
    mc_done = 1; mc_dst = 7; mc_data = 64'h1;
    #1 chk("waw_done_nostall", {63'd0, stall}, 64'd0);
    tick();
    idle();
    issue_valid = 1; rs[0] = 7;
    #1 chk("set_wins_pending", {63'd0, stall}, 64'd1);
    chk("waw_cnt", {32'd0, stall_cnt}, 64'd12);
    idle();
    mc_done = 1; mc_dst = 7;
    tick();

    // x0 reads zero, pc overrides any match on port 0
    idle();
    issue_valid = 1; rf_data[0] = 64'hFFFF;
    exe_regwrite = 1; exe_dst = 0; exe_data = 64'hFF;
    #1 chk("x0_zero", fwd_data[0], 64'd0);
    chk("x0_nostall", {63'd0, stall}, 64'd0);
    idle();
    issue_valid = 1; pc_sel = 1; pc = 64'h8000_0000; rs[0] = 5;
    exe_regwrite = 1; exe_dst = 5; exe_data = 64'h11;
    mem_regwrite = 1; mem_dst = 5; mem_data = 64'h22;
    #1 chk("pc_override", fwd_data[0], 64'h8000_0000);
    tick();

    // reset with two multicycle ops outstanding
    issue_mc_op(5'd3);
    issue_mc_op(5'd4);
    idle();
    issue_valid = 1; rs[0] = 3;
    #1 chk("pre_reset_stall", {63'd0, stall}, 64'd1);
    idle();
    reset_n = 0;
    issue_valid = 1; rs[0] = 4;
    #1 chk("in_reset_nostall", {63'd0, stall}, 64'd0);
    tick();
    reset_n = 1;
    idle();
    #1 chk("post_reset_cnt", {32'd0, stall_cnt}, 64'd0);
    issue_valid = 1; rs[0] = 3; rs[1] = 4;
    #1 chk("post_reset_nostall", {63'd0, stall}, 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
